// File: rtl/aftab_lsu_read_extend.sv
// Byte-serial load read unit: fetches 1/2/4/8 bytes little-endian and sign/zero-extends to XLEN.
// Optional feature macro: ALIGN_CHECK_EN (adds the misaligned port and an ERR path for unaligned loads).
module aftab_lsu_read_extend #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startLoad,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [1:0]        sizeSel,
  input  logic              signedLoad,
  input  logic [7:0]        memDataIn,
  input  logic              memReady,
  output logic              memRead,
  output logic [ADDR_W-1:0] memAddr,
  output logic [XLEN-1:0]   dataOut,
  output logic              done,
`ifdef ALIGN_CHECK_EN
  output logic              misaligned,
`endif
  output logic              busy
);

  localparam int unsigned NB_MAX = XLEN / 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, READ, EXT, ERR} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [XLEN-1:0]     buf_q, buf_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic                done_q, done_d;
  logic                mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;
  logic [1:0]          size_eff;
`ifdef ALIGN_CHECK_EN
  logic                mis_q, mis_d;
`endif

  // Index of the final byte for a given size code.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [1:0] sz);
    case (sz)
      2'b00:   last_cnt = CNT_W'(0);
      2'b01:   last_cnt = CNT_W'(1);
      2'b10:   last_cnt = CNT_W'(3);
      default: last_cnt = CNT_W'(7);
    endcase
  endfunction

  // Keeps the low 8<<sz bits and fills the rest with the (optional) sign bit.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] b, input logic [1:0] sz,
                                             input logic sg);
    logic        s;
    int unsigned nbits;
    case (sz)
      2'b00:   s = b[7];
      2'b01:   s = b[15];
      2'b10:   s = b[31];
      default: s = b[XLEN-1];
    endcase
    nbits = 32'd8 << sz;
    for (int unsigned i = 0; i < XLEN; i++) begin
      extend[i] = (i < nbits) ? b[i] : (sg & s);
    end
  endfunction

  // Doubles degrade to words on a 32-bit datapath.
  assign size_eff = ((XLEN == 32) && (sizeSel == 2'b11)) ? 2'b10 : sizeSel;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    buf_d      = buf_q;
    data_d     = data_q;
    done_d     = 1'b0;
    mem_read_d = 1'b0;
    mem_addr_d = '0;
`ifdef ALIGN_CHECK_EN
    mis_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (startLoad) begin
          base_d = addrIn;
          size_d = size_eff;
          sgn_d  = signedLoad;
          cnt_d  = '0;
`ifdef ALIGN_CHECK_EN
          if ((addrIn[CNT_W-1:0] & last_cnt(size_eff)) != '0) begin
            state_d = ERR;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else
`endif
          begin
            state_d    = READ;
            mem_read_d = 1'b1;
            mem_addr_d = addrIn;
          end
        end
      end
      READ: begin
        mem_read_d = 1'b1;
        mem_addr_d = base_q + ADDR_W'(cnt_q);
        if (memReady) begin
          for (int unsigned j = 0; j < NB_MAX; j++) begin
            if (cnt_q == CNT_W'(j)) buf_d[8*j +: 8] = memDataIn;
          end
          if (cnt_q == last_cnt(size_q)) begin
            // Result and done are registered together so they appear in the EXT cycle.
            state_d    = EXT;
            done_d     = 1'b1;
            mem_read_d = 1'b0;
            mem_addr_d = '0;
            data_d     = extend(buf_d, size_q, sgn_q);
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            mem_addr_d = base_q + ADDR_W'(cnt_d);
          end
        end
      end
      EXT:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      buf_q      <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
`ifdef ALIGN_CHECK_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      buf_q      <= buf_d;
      data_q     <= data_d;
      done_q     <= done_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
`ifdef ALIGN_CHECK_EN
      mis_q      <= mis_d;
`endif
    end
  end

  assign memRead = mem_read_q;
  assign memAddr = mem_addr_q;
  assign dataOut = data_q;
  assign done    = done_q;
  assign busy    = busy_q;
`ifdef ALIGN_CHECK_EN
  assign misaligned = mis_q;
`endif

endmodule

// File: tb/tb_aftab_lsu_read_extend.sv
// Scoreboard bench for aftab_lsu_read_extend: stimulus pushes expected addresses/results, monitor checks.
module tb_aftab_lsu_read_extend;

  logic        clk = 1'b0;
  logic        rst;
  logic        startLoad;
  logic [31:0] addrIn;
  logic [1:0]  sizeSel;
  logic        signedLoad;
  logic [7:0]  memDataIn;
  logic        memReady;
  logic        memRead;
  logic [31:0] memAddr;
  logic [31:0] dataOut;
  logic        done;
  logic        busy;
`ifdef ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];
  logic [31:0] last_exp = 32'h0;

  always #5 clk = ~clk;

  aftab_lsu_read_extend dut (
    .clk(clk), .rst(rst), .startLoad(startLoad), .addrIn(addrIn), .sizeSel(sizeSel),
    .signedLoad(signedLoad), .memDataIn(memDataIn), .memReady(memReady), .memRead(memRead),
    .memAddr(memAddr), .dataOut(dataOut), .done(done),
`ifdef ALIGN_CHECK_EN
    .misaligned(misaligned),
`endif
    .busy(busy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every read cycle checks the address; every done pops the expected result.
  always @(negedge clk) begin
    if (!rst) begin
      if (memRead) begin
        chk("busy_in_read", 64'(busy), 64'd1);
        if (addr_q.size() == 0) chk("unexpected_read", 64'(memAddr), 64'hDEAD);
        else begin
          chk("memAddr", 64'(memAddr), 64'(addr_q[0]));
          if (memReady) void'(addr_q.pop_front());
        end
      end
      if (done) begin
        chk("done_vs_memRead", 64'(memRead), 64'd0);
        if (data_q.size() == 0) chk("unexpected_done", 64'(dataOut), 64'hDEAD);
        else chk("dataOut", 64'(dataOut), 64'(data_q.pop_front()));
      end
    end
  end

  // One load; bytes[7:0] is the first byte returned. Ends in the done cycle (+1 time unit).
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [31:0] bytes, input int stall, input logic intr,
                         input logic [31:0] exp);
    int n;
    n = 1 << ((sz == 2'b11) ? 2 : sz);
`ifdef ALIGN_CHECK_EN
    if ((a % 32'(n)) != 0) begin
      data_q.push_back(last_exp);
      @(posedge clk); #1;
      startLoad = 1'b1; addrIn = a; sizeSel = sz; signedLoad = sg;
      @(posedge clk); #1;
      startLoad = 1'b0;
      chk("misaligned", 64'(misaligned), 64'd1);
      chk("mis_done", 64'(done), 64'd1);
      return;
    end
`endif
    data_q.push_back(exp);
    last_exp = exp;
    for (int k = 0; k < n; k++) addr_q.push_back(a + 32'(k));
    @(posedge clk); #1;
    startLoad = 1'b1; addrIn = a; sizeSel = sz; signedLoad = sg; memReady = 1'b0;
    @(posedge clk); #1;
    startLoad = 1'b0;
    for (int k = 0; k < n; k++) begin
      for (int s = 0; s < stall; s++) begin
        memReady = 1'b0;
        if (intr && k == 1 && s == 0) begin
          startLoad = 1'b1; addrIn = 32'h999; sizeSel = 2'b00;
        end else startLoad = 1'b0;
        @(posedge clk); #1;
      end
      startLoad = 1'b0;
      memReady  = 1'b1;
      memDataIn = bytes[8*k +: 8];
      @(posedge clk); #1;
    end
    memReady  = 1'b0;
    memDataIn = 8'h5A;
    if (stall == 0) chk("latency_done", 64'(done), 64'd1);
  endtask

  initial begin
    rst = 1'b1; startLoad = 1'b0; addrIn = '0; sizeSel = '0; signedLoad = 1'b0;
    memDataIn = 8'hA5; memReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_memRead", 64'(memRead), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dataOut", 64'(dataOut), 64'd0);
    chk("rst_memAddr", 64'(memAddr), 64'd0);
    rst = 1'b0;

    do_load(32'h100, 2'b00, 1'b1, 32'h80, 0, 1'b0, 32'hFFFFFF80);
    do_load(32'h202, 2'b01, 1'b0, 32'hF234, 0, 1'b0, 32'h0000F234);
    do_load(32'h202, 2'b01, 1'b1, 32'hF234, 0, 1'b0, 32'hFFFFF234);
    do_load(32'h10, 2'b10, 1'b0, 32'h12345678, 3, 1'b0, 32'h12345678);
    do_load(32'h300, 2'b00, 1'b0, 32'h80, 0, 1'b0, 32'h00000080);
    do_load(32'h400, 2'b01, 1'b1, 32'h7FFF, 0, 1'b0, 32'h00007FFF);
    do_load(32'h500, 2'b11, 1'b1, 32'hDDCCBBAA, 0, 1'b0, 32'hDDCCBBAA);
    do_load(32'h600, 2'b10, 1'b1, 32'h84030201, 1, 1'b0, 32'h84030201);
    do_load(32'hFFFFFFFF, 2'b01, 1'b1, 32'h8001, 0, 1'b0, 32'hFFFF8001);
    do_load(32'h700, 2'b10, 1'b0, 32'hCAFEF00D, 2, 1'b1, 32'hCAFEF00D);
    do_load(32'h102, 2'b10, 1'b0, 32'h44332211, 0, 1'b0, 32'h44332211);

    // Reset during the second byte of a word read.
    addr_q.push_back(32'h10); addr_q.push_back(32'h11);
    @(posedge clk); #1;
    startLoad = 1'b1; addrIn = 32'h10; sizeSel = 2'b10; signedLoad = 1'b0;
    @(posedge clk); #1;
    startLoad = 1'b0; memReady = 1'b1; memDataIn = 8'h78;
    @(posedge clk); #1;
    memReady = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_memRead", 64'(memRead), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_dataOut", 64'(dataOut), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    addr_q.delete();
    rst = 1'b0;
    last_exp = 32'h0;
    do_load(32'h800, 2'b00, 1'b1, 32'h7F, 0, 1'b0, 32'h0000007F);

    repeat (3) @(posedge clk);
    #1;
    chk("end_busy", 64'(busy), 64'd0);
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
    chk("data_q_empty", 64'(data_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
